// File: rtl/pad_loop_checker.sv
// Loopback BIST for the south padring loop pair: sends an LFSR stream out on
// one pad, resynchronises the return, and counts bit mismatches.
module pad_loop_checker #(
  parameter int          LOOP_DELAY = 2,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_bits,
  input  logic        loop_in,
  output logic        loop_out,
  output logic        loop_oe,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [15:0] SEED_STEP =
    {SEED[0] ^ SEED[2] ^ SEED[3] ^ SEED[5], SEED[15:1]};
  localparam logic [3:0]  DRAIN_LOAD = 4'(LOOP_DELAY);

  state_e                  state_q;
  logic [15:0]             lfsr_q;
  logic [15:0]             rem_q;
  logic [3:0]              drain_q;
  logic [1:0]              sync_q;
  logic [LOOP_DELAY-1:0]   exp_q, exp_d;
  logic [LOOP_DELAY-1:0]   vld_q, vld_d;
  logic                    tx_vld_q;
  logic                    loop_out_q;
  logic                    loop_oe_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    pass_q;
  logic [15:0]             err_q, err_d;
  logic [15:0]             lfsr_step;
  logic                    rx;
  logic                    mismatch;

  assign rx        = sync_q[1];
  assign lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign mismatch  = vld_q[LOOP_DELAY-1] & (rx ^ exp_q[LOOP_DELAY-1]);

  // The delay lines are fed from the loop_out register, so their tail lines
  // up with the second synchronizer flop after LOOP_DELAY stages.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    exp_d    = exp_q;
    vld_d    = vld_q;
    exp_d[0] = loop_out_q;
    vld_d[0] = tx_vld_q;
    for (int i = 1; i < LOOP_DELAY; i++) begin
      exp_d[i] = exp_q[i-1];
      vld_d[i] = vld_q[i-1];
    end
  end

  always_comb begin
    err_d = err_q;
    if (mismatch && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  // NOTE: all state below is written with non-blocking assignments so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      rem_q      <= '0;
      drain_q    <= '0;
      sync_q     <= '0;
      exp_q      <= '0;
      vld_q      <= '0;
      tx_vld_q   <= 1'b0;
      loop_out_q <= 1'b0;
      loop_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      sync_q <= {sync_q[0], loop_in};
      exp_q  <= exp_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_q     <= '0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b1;
            loop_oe_q <= 1'b1;
            // Bit 0 goes out on the accepting edge so bit k spans E0+k..E0+k+1.
            if (num_bits == 16'd0) begin
              state_q    <= S_DRAIN;
              drain_q    <= DRAIN_LOAD;
              lfsr_q     <= SEED;
              loop_out_q <= 1'b0;
              tx_vld_q   <= 1'b0;
            end else begin
              state_q    <= S_RUN;
              lfsr_q     <= SEED_STEP;
              loop_out_q <= SEED[0];
              tx_vld_q   <= 1'b1;
              rem_q      <= num_bits - 16'd1;
            end
          end
        end

        S_RUN: begin
          if (rem_q == 16'd0) begin
            state_q    <= S_DRAIN;
            drain_q    <= DRAIN_LOAD;
            loop_out_q <= 1'b0;
            tx_vld_q   <= 1'b0;
          end else begin
            loop_out_q <= lfsr_q[0];
            tx_vld_q   <= 1'b1;
            lfsr_q     <= lfsr_step;
            rem_q      <= rem_q - 16'd1;
          end
        end

        // One extra cycle beyond LOOP_DELAY lets the last compare land in
        // err_q before pass is judged.
        S_DRAIN: begin
          if (drain_q == 4'd0) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            pass_q    <= (err_q == 16'd0);
            loop_oe_q <= 1'b0;
          end else begin
            drain_q <= drain_q - 4'd1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign loop_out  = loop_out_q;
  assign loop_oe   = loop_oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule
